result_bcd_converter: RTL and testbench
=======================================

Name: result_bcd_converter

Overview:
- Downstream consumer of the recurrence datapath's `result` word: a multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble).
- The controller pulses `start` when the datapath's `done` is seen, with `bin_in` wired to `result`.
- The block produces packed decimal digits for the display/output stage.
- A valid/ack handshake holds the digits until they are consumed.

Parameters:
- IN_W, 21, width of the binary input (matches the datapath result width 5*size+1 with size=4).
- DIGITS, 7, number of BCD output digits. Must satisfy 10^DIGITS > 2^IN_W - 1; the implementation checks this at elaboration.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  conversion request; sampled only in IDLE
- bin_in  input  IN_W  unsigned binary value; captured on the edge that accepts start
- ack  input  1  consumer acknowledge; sampled only in DONE
- busy  output  1  high in SHIFT state
- valid  output  1  high in DONE state; bcd_out is meaningful
- bcd_out  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, valid=0, bcd_out=0, internal shift register and counter cleared. Reset asserted mid-conversion aborts it immediately; no partial result is ever flagged valid.
- Registers:
  - working register {bcd[4*DIGITS-1:0], bin[IN_W-1:0]}
  - iteration counter, width clog2(IN_W+1)
  - 2-bit state
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: bin<=bin_in, bcd<=0, cnt<=IN_W, state->SHIFT.
  - Otherwise hold. bcd_out keeps the last result.
- SHIFT, once per cycle:
  - Each BCD nibble >=5 gets +3; nibbles are corrected in parallel from the pre-shift value.
  - The whole {bcd,bin} then shifts left by 1, and cnt decrements.
  - On the iteration where cnt==1, the corrected and shifted bcd is loaded into bcd_out, valid<=1, state->DONE.
  - start is ignored while busy.
- Latency: valid rises on exactly the IN_W-th rising edge after the edge that accepted start (21 cycles by default). busy is high for those IN_W cycles.
- DONE:
  - valid=1, bcd_out stable.
  - On ack=1: valid<=0, state->IDLE on that edge. start in the same cycle is ignored and must be re-asserted in IDLE.
  - Without ack, the block holds indefinitely.
- bcd_out is a registered output. It changes only on DONE entry or on reset, never during SHIFT.
- Arithmetic: nibble add is 4-bit with no carry out (max 9+3=12 fits). No saturation is needed given the DIGITS constraint.
- bin_in = 0: all iterations run, result is all-zero digits, same latency.
- bin_in = 2^IN_W-1 converts exactly; no overflow path exists.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when loading bcd_out on DONE entry, every leading zero digit above the most significant nonzero digit is replaced by 4'hF (display blank code). Digit 0 is never blanked, so value 0 yields 0xFFFFFF0 for DIGITS=7. Non-leading zeros are unaffected.
- Undefined: no blanking; bcd_out is pure packed BCD.
- Latency and handshake are identical in both builds.

Test Plan:
- rst low 2 cycles, release -> busy=0, valid=0, bcd_out=0; then start with bin_in=797161 (value for entry 13) -> valid on the 21st edge after start, bcd_out=0x0797161; busy high for exactly 21 cycles.
- bin_in=2097151 (max) -> bcd_out=0x2097151. bin_in=0 -> bcd_out=0x0000000 (0xFFFFFF0 with LEADING_ZERO_BLANK_EN); bin_in=41 -> 0x0000041 (0xFFFFF41 blanked).
- Hold ack=0 for 50 cycles after valid -> valid and bcd_out stay constant; ack=1 one cycle -> valid=0 next edge, state IDLE, bcd_out retained.
- start=1 continuously from acceptance through SHIFT with bin_in changed to 5 mid-conversion -> the first result is still correct (797161). In DONE, assert start together with ack -> no new conversion begins until start is seen in IDLE.
- Assert rst low at cycle 10 of a conversion -> busy/valid/bcd_out=0 immediately (async). After release, start with 265721 -> 0x0265721 after 21 cycles.
- Back-to-back: 1093, ack, then 29525 started the cycle after IDLE re-entry -> 0x0001093 then 0x0029525, each with 21-cycle latency.

Source files
------------

// File: rtl/result_bcd_converter.sv
// result_bcd_converter: multi-cycle binary-to-BCD converter (shift-and-add-3).
// Takes the recurrence datapath result word and converts it to packed decimal
// digits. Each conversion takes IN_W cycles. The digits are held behind a
// valid/ack handshake until the consumer takes them.
// Optional build macro: LEADING_ZERO_BLANK_EN. When defined, leading zero digits
// above the most significant nonzero digit are replaced by 4'hF on output.
module result_bcd_converter #(
   parameter int IN_W   = 21,
   parameter int DIGITS = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [IN_W-1:0]       bin_in,
   input  logic                  ack,
   output logic                  busy,
   output logic                  valid,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int WORK_W = BCD_W + IN_W;
   localparam int CNT_W  = $clog2(IN_W + 1);

   // 10^n in a wide word, so the digit-count check works for any practical size
   function automatic logic [127:0] pow10(input int n);
      logic [127:0] p;
      p = 128'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 128'd10;
      end
      return p;
   endfunction

   localparam logic [127:0] MAX_IN = (128'd1 << IN_W) - 128'd1;

   // DIGITS must be wide enough to hold the largest possible input value
   generate
      if (!(pow10(DIGITS) > MAX_IN)) begin : g_digits_check
         $error("result_bcd_converter: DIGITS too small for IN_W");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic [BCD_W-1:0]  bcd_reg;
   logic [IN_W-1:0]   bin_reg;
   logic [BCD_W-1:0]  bcd_out_reg;

   logic [BCD_W-1:0]  bcd_corr;
   logic [WORK_W-1:0] work_shift;
   logic [BCD_W-1:0]  bcd_shift;
   logic [IN_W-1:0]   bin_shift;
   logic [BCD_W-1:0]  load_value;
   logic              last_iter;

   // Add-3 correction on every nibble in parallel, all from the pre-shift value
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_corr
         assign bcd_corr[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                      (bcd_reg[4*gi +: 4] + 4'd3) :
                                       bcd_reg[4*gi +: 4];
      end
   endgenerate

   // Shift the corrected working register left by one; the bin MSB enters bcd
   assign work_shift = {bcd_corr, bin_reg} << 1;
   assign bcd_shift  = work_shift[WORK_W-1 -: BCD_W];
   assign bin_shift  = work_shift[IN_W-1:0];
   assign last_iter  = (cnt_reg == CNT_W'(1));

`ifdef LEADING_ZERO_BLANK_EN
   // lead_zero[k]: digit k and every digit above it are zero
   logic [DIGITS:1] lead_zero;
   assign lead_zero[DIGITS] = 1'b1;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_blank
         if (gi == 0) begin : g_units
            // the units digit is always shown, so a zero result reads "0"
            assign load_value[3:0] = bcd_shift[3:0];
         end else begin : g_upper
            assign lead_zero[gi] = (bcd_shift[4*gi +: 4] == 4'd0) && lead_zero[gi+1];
            assign load_value[4*gi +: 4] = lead_zero[gi] ? 4'hF : bcd_shift[4*gi +: 4];
         end
      end
   endgenerate
`else
   assign load_value = bcd_shift;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: accept start only in IDLE, ack only in DONE
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start)     state_next = SHIFT;
         SHIFT:   if (last_iter) state_next = DONE;
         DONE:    if (ack)       state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Working register, iteration counter and output digit register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg     <= '0;
         bcd_reg     <= '0;
         bin_reg     <= '0;
         bcd_out_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  bin_reg <= bin_in;
                  bcd_reg <= '0;
                  cnt_reg <= CNT_W'(IN_W);
               end
            end
            SHIFT: begin
               bcd_reg <= bcd_shift;
               bin_reg <= bin_shift;
               cnt_reg <= cnt_reg - CNT_W'(1);
               if (last_iter) begin
                  bcd_out_reg <= load_value;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state_reg == SHIFT);
   assign valid   = (state_reg == DONE);
   assign bcd_out = bcd_out_reg;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Testbench for result_bcd_converter: directed cases plus random values, each
// checked against a decimal model computed with plain division by ten.
module tb_result_bcd_converter;

   localparam int IN_W   = 21;
   localparam int DIGITS = 7;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                start = 1'b0;
   logic [IN_W-1:0]     bin_in = '0;
   logic                ack = 1'b0;
   logic                busy;
   logic                valid;
   logic [4*DIGITS-1:0] bcd_out;

   int checks = 0;
   int errors = 0;

   result_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bin_in  (bin_in),
      .ack     (ack),
      .busy    (busy),
      .valid   (valid),
      .bcd_out (bcd_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Decimal digits of v, units first; optionally blank leading zeros
   function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
      logic [4*DIGITS-1:0] r;
      int unsigned x;
      int nd;
      r = '0;
      x = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      nd = 1;
      x = v / 10;
      while (x != 0) begin
         nd++;
         x = x / 10;
      end
`ifdef LEADING_ZERO_BLANK_EN
      for (int d = nd; d < DIGITS; d++) r[4*d +: 4] = 4'hF;
`endif
      return r;
   endfunction

   // One conversion: start, wait (bounded) for valid, check latency and digits
   task automatic convert(input int unsigned v, input bit hold_start);
      logic [4*DIGITS-1:0] prev;
      int n;
      int busy_cnt;
      bit stable;
      prev   = bcd_out;
      start  = 1'b1;
      bin_in = IN_W'(v);
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      n = 0;
      busy_cnt = 0;
      stable = 1'b1;
      while (!valid && n < 100) begin
         if (busy) busy_cnt++;
         if (bcd_out !== prev) stable = 1'b0;
         if (hold_start && n == 5) bin_in = IN_W'(5);
         @(posedge clk); #1;
         n++;
      end
      check("latency", n, 21);
      check("busy_cycles", busy_cnt, 21);
      check("bcd_hold_in_shift", {31'd0, stable}, 32'd1);
      check("busy_in_done", {31'd0, busy}, 32'd0);
      check("bcd_out", {4'd0, bcd_out}, {4'd0, ref_bcd(v)});
      $display("conv bin=%0d bcd_out=0x%07h expected=0x%07h latency=%0d", v, bcd_out, ref_bcd(v), n);
   endtask

   task automatic do_ack();
      logic [4*DIGITS-1:0] kept;
      kept = bcd_out;
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      check("valid_after_ack", {31'd0, valid}, 32'd0);
      check("busy_after_ack", {31'd0, busy}, 32'd0);
      check("bcd_retained", {4'd0, bcd_out}, {4'd0, kept});
   endtask

   initial begin
      bit held;
      logic [4*DIGITS-1:0] snap;
      int unsigned edge_vals [6] = '{9, 10, 99, 100, 999999, 1000000};

      // reset
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_bcd", {4'd0, bcd_out}, 32'd0);

      // first conversion, then hold without ack for 50 cycles
      convert(797161, 1'b0);
      snap = bcd_out;
      held = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (!valid || bcd_out !== snap) held = 1'b0;
      end
      check("hold_without_ack", {31'd0, held}, 32'd1);
      do_ack();

      convert(2097151, 1'b0);
      do_ack();
      convert(0, 1'b0);
      do_ack();
      convert(41, 1'b0);
      do_ack();

      // start held through the whole conversion with bin_in changing midway
      convert(797161, 1'b1);
      ack = 1'b1;                // start still high alongside ack
      @(posedge clk); #1;
      ack = 1'b0;
      start = 1'b0;
      check("start_ack_valid", {31'd0, valid}, 32'd0);
      check("start_ack_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check("no_restart_busy", {31'd0, busy}, 32'd0);

      // asynchronous reset in the middle of a conversion
      start = 1'b1;
      bin_in = IN_W'(797161);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_valid", {31'd0, valid}, 32'd0);
      check("abort_bcd", {4'd0, bcd_out}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("post_abort_valid", {31'd0, valid}, 32'd0);
      convert(265721, 1'b0);
      do_ack();

      // back-to-back conversions
      convert(1093, 1'b0);
      do_ack();
      convert(29525, 1'b0);
      do_ack();

      // decade boundaries
      foreach (edge_vals[i]) begin
         convert(edge_vals[i], 1'b0);
         do_ack();
      end

      // random values
      for (int i = 0; i < 10; i++) begin
         convert($urandom_range(0, (1 << IN_W) - 1), 1'b0);
         do_ack();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
